// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for bit-serial arithmetic blocks: FSM state encoding and
// a helper that sizes bit counters from an operand width.
package serial_subtractor_pkg;

    // Two-state controller: waiting for a request, or shifting bits through the cell.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bits needed to count from 0 to width-1. It is clamped to at least one
    // bit so that a degenerate width still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned width);
        if (width < 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with bo the borrow out of this bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference is the parity of the three inputs. Borrow is raised when
    // x=0,y=1, or when x==y and a borrow is already pending.
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin (mod 2^WIDTH), with one
// bit resolved per clock through a single full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;
    logic               bout_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;

    // Combinational next values for the shifting datapath.
    logic               cell_d;
    logic               cell_bo;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_d;
    logic [WIDTH-1:0]   diff_d;
    logic [CNT_W-1:0]   cnt_d;

    // The single arithmetic cell always looks at the current operand LSBs and
    // the borrow carried over from the previous bit.
    full_subtractor u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Shift values for one RUN step: operands move right, the new difference
    // bit enters at the MSB so that after WIDTH steps bit 0 sits at position 0.
    always_comb begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_ONE;
    end

    // Controller and datapath registers; done is a one-cycle pulse raised on
    // the edge that resolves the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    diff_q   <= diff_d;
                    borrow_q <= cell_bo;
                    cnt_q    <= cnt_d;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        bout_q  <= cell_bo;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers, so they are glitch-free and hold
    // between done and the next accepted start.
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        diff = diff_q;
        bout = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results,
// a separate monitor pops and compares whenever done pulses.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    logic fx, fy, fbi, fd, fbo;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    full_subtractor u_fs (
        .x  (fx),
        .y  (fy),
        .bi (fbi),
        .d  (fd),
        .bo (fbo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain unsigned subtraction in WIDTH+1 bits; the top bit is the borrow.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bi);
        return {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=diff 0x%0h bout %0b required=no done",
                             diff, bout);
                end else begin
                    e = exp_q.pop_front();
                    $display("result diff=0x%0h bout=%0b expected diff=0x%0h bout=%0b",
                             diff, bout, e[W-1:0], e[W]);
                    check("diff", 64'(diff), 64'(e[W-1:0]));
                    check("bout", 64'(bout), 64'(e[W]));
                end
            end
        end
    end

    // One complete operation from idle, with latency and busy-length checks.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        int n;
        int bc;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        exp_q.push_back(model(av, bv, bi));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        n  = 1;
        bc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 4 * W) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) bc++;
        end
        check("latency", 64'(n), 64'(W + 1));
        check("busy_cycles", 64'(bc), 64'(W));
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'(0));
    endtask

    initial begin
        int n;
        int n1;
        int snap;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        fx = 1'b0; fy = 1'b0; fbi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_diff", 64'(diff), 64'(0));
        check("reset_bout", 64'(bout), 64'(0));
        rst = 1'b0;

        // Full-subtractor truth table against integer arithmetic.
        for (int i = 0; i < 8; i++) begin
            int r;
            fx = i[2]; fy = i[1]; fbi = i[0];
            #1;
            r = int'(fx) - int'(fy) - int'(fbi);
            $display("cell x=%0b y=%0b bi=%0b d=%0b bo=%0b", fx, fy, fbi, fd, fbo);
            check("cell_d", 64'(fd), 64'(r & 1));
            check("cell_bo", 64'(fbo), 64'(r < 0));
        end

        // Directed operations.
        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'hFF, 8'h00, 1'b0);
        run_op(8'h5A, 8'h5A, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1);

        // Start pulsed mid-RUN must be ignored.
        snap = done_cnt;
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h05, 8'h03, 1'b0));
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3 * W) @(negedge clk);
        check("midrun_done_count", 64'(done_cnt - snap), 64'(1));
        check("midrun_idle", 64'(busy), 64'(0));

        // Reset during RUN, coinciding with a start request: reset wins.
        snap = done_cnt;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_diff", 64'(diff), 64'(0));
        check("rst_bout", 64'(bout), 64'(0));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_rejected", 64'(busy), 64'(0));
        repeat (2 * W) @(negedge clk);
        check("rst_no_done", 64'(done_cnt - snap), 64'(0));

        // Start held high: back-to-back operations, second accepted in the done cycle.
        @(negedge clk);
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h80, 8'h01, 1'b0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 4 * W);
        check("b2b_first_latency", 64'(n), 64'(W + 1));
        n1 = n;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        exp_q.push_back(model(a, b, bin));
        @(negedge clk); n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 8 * W) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap", 64'(n - n1), 64'(W + 1));

        // Randomized operations.
        for (int k = 0; k < 30; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2 * W) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first WIDTH-bit subtractor computing a - b - bin, one bit per clock, using a single full-subtractor cell.
- Subtraction counterpart of the combinational full-adder cell; used where area matters more than latency.
- start/busy/done handshake for the requester; result held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only while idle (busy=0).
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse; diff and bout are valid from this cycle.
- diff  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin, unsigned.

Behaviour:
- Reset values, with rst=1 at a rising edge:
  - busy=0, done=0, diff=0, bout=0.
  - Internal a/b shift registers=0, borrow flop=0, bit counter=0, state=IDLE.
- States:
  - IDLE: busy=0. When start=1 at an edge, load a, b and bin; counter=0; go to RUN; busy=1 from the next cycle.
  - RUN: each edge feeds the current a LSB, b LSB and the borrow flop into the full-subtractor cell.
    - Difference bit shifts into the MSB of the diff shift register; a and b shift right.
    - Borrow flop takes the cell's borrow; counter increments.
    - On the edge where counter == WIDTH-1: final bit lands, bout is registered, state returns to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: start sampled at edge E0; bits processed at E1..EWIDTH; done high in the cycle after EWIDTH. Start-to-done is WIDTH cycles; throughput is one operation per WIDTH+1 cycles.
- Cell equations: d = x ^ y ^ bi; bo = (~x & y) | (~(x ^ y) & bi).
- diff behaviour while busy=1:
  - diff is the shift register and changes every cycle; it is not valid.
  - diff and bout hold their values from done until the next accepted start.
- Boundary conditions:
  - start while busy=1: ignored; operands are not re-captured.
  - start in the cycle done=1: state is IDLE, so it is accepted; done still pulses once.
  - start held high continuously: back-to-back operations, each WIDTH+1 cycles apart.
  - a == b, bin=0: diff=0, bout=0. Full underflow wraps modulo 2^WIDTH, with bout=1.
  - rst during RUN: operation aborted, all reset values applied at that edge, no done pulse.
  - rst and start in the same cycle: rst wins; start is not accepted.
  - Inputs a, b and bin are don't-care except on the accepting edge.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, RUN=1'b1);
  - a counter-width function ($clog2(WIDTH)) usable by other serial arithmetic blocks.
- One sub-module: full_subtractor, purely combinational, with inputs x, y, bi and outputs d, bo. It is instantiated once, and the bench also checks it standalone.

Test Plan:
- full_subtractor standalone, all 8 (x,y,bi) combinations -> d/bo truth table exact, e.g. (0,1,1) -> d=0, bo=1; (1,0,0) -> d=1, bo=0.
- WIDTH=8:
  - a=0x05, b=0x03, bin=0 -> done 8 cycles after start edge; diff=0x02, bout=0; busy high for exactly 8 cycles.
  - a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
  - a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
  - a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
- start pulsed again mid-RUN with a=0x10, b=0x01 after a=0x05, b=0x03 -> result 0x02 only; a single done pulse; no second operation.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, diff=0, bout=0, and no done follows. Then start a=0x80, b=0x01 with start held high -> diff=0x7F, bout=0, and a back-to-back second done 9 cycles later.
